// File: rtl/calcu_alu_seq_if.sv
// rtl/calcu_alu_seq_if.sv - start/result handshake bundle for the sequential calculator ALU
interface calcu_alu_seq_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [2:0]       operacion;
    logic [WIDTH-1:0] datoA;
    logic [WIDTH-1:0] datoB;
    logic [WIDTH-1:0] resultado;
    logic             ready;
    logic             busy;
    logic             error;

    modport master (
        output start, operacion, datoA, datoB,
        input  resultado, ready, busy, error
    );

    modport slave (
        input  start, operacion, datoA, datoB,
        output resultado, ready, busy, error
    );
endinterface

// File: rtl/calcu_alu_seq.sv
// rtl/calcu_alu_seq.sv - multi-cycle unsigned ALU: 1-cycle add/sub, bit-serial mul/div/mod
module calcu_alu_seq #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    calcu_alu_seq_if.slave     bus
);
    localparam int CW = $clog2(WIDTH) + 1;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_MUL = 3'd2;
    localparam logic [2:0] OP_DIV = 3'd3;
    localparam logic [2:0] OP_MOD = 3'd4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           nxt;
    logic [2:0]       op_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] res_q;
    logic             err_q;
    logic             ready_q;

    logic             in_illegal;
    logic             in_divzero;
    logic             fast;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_sh;
    logic [WIDTH:0]   div_diff;
    logic             div_ge;
    logic [WIDTH-1:0] step_hi;
    logic [WIDTH-1:0] step_lo;
    logic [WIDTH:0]   add_full;

    assign in_illegal = (bus.operacion > OP_MOD);
    assign in_divzero = ((bus.operacion == OP_DIV) || (bus.operacion == OP_MOD)) && (bus.datoB == '0);
    assign fast       = in_illegal || in_divzero;

    // hi/lo double as {accumulator, multiplier} for MUL and {remainder, dividend} for DIV/MOD
    assign mul_sum  = {1'b0, hi} + (lo[0] ? {1'b0, a_q} : {(WIDTH+1){1'b0}});
    assign div_sh   = {hi, lo[WIDTH-1]};
    assign div_ge   = (div_sh >= {1'b0, b_q});
    assign div_diff = div_sh - {1'b0, b_q};
    assign add_full = {1'b0, a_q} + {1'b0, b_q};

    always_comb begin
        step_hi = hi;
        step_lo = lo;
        if (op_q == OP_MUL) begin
            step_hi = mul_sum[WIDTH:1];
            step_lo = {mul_sum[0], lo[WIDTH-1:1]};
        end else begin
            step_hi = div_ge ? div_diff[WIDTH-1:0] : div_sh[WIDTH-1:0];
            step_lo = {lo[WIDTH-2:0], div_ge};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= nxt;
        end
    end

    always_comb begin
        nxt = state;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    nxt = fast ? DONE : CALC;
                end
            end
            CALC: begin
                if ((op_q == OP_ADD) || (op_q == OP_SUB) || (cnt == CW'(WIDTH - 1))) begin
                    nxt = DONE;
                end
            end
            DONE:    nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            hi      <= '0;
            lo      <= '0;
            cnt     <= '0;
            res_q   <= '0;
            err_q   <= 1'b0;
            ready_q <= 1'b0;
        end else begin
            // ready trails the DONE state by one edge so it lands on the IDLE cycle
            ready_q <= (state == DONE);
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        op_q <= bus.operacion;
                        a_q  <= bus.datoA;
                        b_q  <= bus.datoB;
                        cnt  <= '0;
                        hi   <= '0;
                        lo   <= (bus.operacion == OP_MUL) ? bus.datoB : bus.datoA;
                        if (in_illegal) begin
                            res_q <= '0;
                            err_q <= 1'b1;
                        end else if (in_divzero) begin
                            res_q <= (bus.operacion == OP_DIV) ? {WIDTH{1'b1}} : bus.datoA;
                            err_q <= 1'b1;
                        end
                    end
                end
                CALC: begin
                    cnt <= cnt + CW'(1);
                    hi  <= step_hi;
                    lo  <= step_lo;
                    if (nxt == DONE) begin
                        case (op_q)
                            OP_ADD: begin
                                res_q <= add_full[WIDTH-1:0];
                                err_q <= add_full[WIDTH];
                            end
                            OP_SUB: begin
                                res_q <= a_q - b_q;
                                err_q <= (a_q < b_q);
                            end
                            OP_MUL: begin
                                res_q <= step_lo;
                                err_q <= (step_hi != '0);
                            end
                            OP_DIV: begin
                                res_q <= step_lo;
                                err_q <= 1'b0;
                            end
                            default: begin
                                res_q <= step_hi;
                                err_q <= 1'b0;
                            end
                        endcase
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.resultado = res_q;
    assign bus.error     = err_q;
    assign bus.ready     = ready_q;
    assign bus.busy      = (state != IDLE);
endmodule

// File: tb/tb_calcu_alu_seq.sv
// tb/tb_calcu_alu_seq.sv - randomized and directed bench for calcu_alu_seq against an arithmetic model
module tb_calcu_alu_seq;
    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    calcu_alu_seq_if #(.WIDTH(32)) bus ();

    calcu_alu_seq #(.WIDTH(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] r, output logic e, output int lat);
        logic [63:0] p;
        case (op)
            3'd0: begin p = 64'(a) + 64'(b); r = p[31:0]; e = p[32]; lat = 2; end
            3'd1: begin r = a - b; e = (a < b); lat = 2; end
            3'd2: begin p = 64'(a) * 64'(b); r = p[31:0]; e = (p[63:32] != 0); lat = 33; end
            3'd3: begin
                if (b == 0) begin r = 32'hFFFFFFFF; e = 1'b1; lat = 1; end
                else begin r = a / b; e = 1'b0; lat = 33; end
            end
            3'd4: begin
                if (b == 0) begin r = a; e = 1'b1; lat = 1; end
                else begin r = a % b; e = 1'b0; lat = 33; end
            end
            default: begin r = 32'd0; e = 1'b1; lat = 1; end
        endcase
    endtask

    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input bit inject);
        logic [31:0] er;
        logic        ee;
        int          elat;
        int          got;
        int          busy_hi;
        model(op, a, b, er, ee, elat);
        @(negedge clk);
        bus.start = 1'b1; bus.operacion = op; bus.datoA = a; bus.datoB = b;
        @(posedge clk); #1;
        bus.start = 1'b0; bus.datoA = $urandom; bus.datoB = $urandom; bus.operacion = 3'($urandom);
        got = -1;
        busy_hi = 0;
        for (int k = 0; k <= 80; k++) begin
            if (k > 0) begin @(posedge clk); #1; end
            if (bus.ready) begin got = k; break; end
            if (bus.busy) busy_hi++;
            if (inject && k == 5) begin
                bus.start = 1'b1; bus.operacion = 3'd0; bus.datoA = $urandom; bus.datoB = $urandom;
            end
            if (inject && k == 6) bus.start = 1'b0;
        end
        check($sformatf("latency op%0d", op), 64'(got), 64'(elat));
        check($sformatf("busy_cycles op%0d", op), 64'(busy_hi), 64'(elat));
        check($sformatf("busy_low op%0d", op), 64'(bus.busy), 64'(0));
        check($sformatf("result op%0d a=%0h b=%0h", op, a, b), 64'(bus.resultado), 64'(er));
        check($sformatf("error op%0d a=%0h b=%0h", op, a, b), 64'(bus.error), 64'(ee));
        @(posedge clk); #1;
        check("ready_pulse", 64'(bus.ready), 64'(0));
    endtask

    initial begin
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  op;
        int          ready_seen;
        checks = 0;
        failures = 0;
        rst_n = 1'b0;
        bus.start = 1'b0; bus.operacion = 3'd0; bus.datoA = '0; bus.datoB = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_resultado", 64'(bus.resultado), 64'(0));
        check("rst_ready", 64'(bus.ready), 64'(0));
        check("rst_busy", 64'(bus.busy), 64'(0));
        check("rst_error", 64'(bus.error), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;

        run_op(3'd4, 32'd5, 32'd500, 1'b0);
        run_op(3'd3, 32'd500, 32'd5, 1'b0);
        run_op(3'd3, 32'd7, 32'd0, 1'b0);
        run_op(3'd0, 32'hFFFFFFFF, 32'd1, 1'b0);
        run_op(3'd1, 32'd3, 32'd5, 1'b0);
        run_op(3'd2, 32'h10000, 32'h10000, 1'b0);
        run_op(3'd2, 32'd1234, 32'd5678, 1'b0);
        run_op(3'd6, 32'd9, 32'd9, 1'b0);
        run_op(3'd2, 32'hFFFFFFFF, 32'd1, 1'b1);
        run_op(3'd2, 32'd0, 32'hFFFFFFFF, 1'b0);
        run_op(3'd3, 32'd3, 32'd9, 1'b0);
        run_op(3'd4, 32'd3, 32'd9, 1'b0);
        run_op(3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
        run_op(3'd4, 32'h80000001, 32'h80000001, 1'b0);
        run_op(3'd4, 32'd77, 32'd0, 1'b0);

        // back-to-back ADDs with start held through DONE
        @(negedge clk);
        bus.start = 1'b1; bus.operacion = 3'd0; bus.datoA = 32'd10; bus.datoB = 32'd20;
        @(posedge clk); #1;
        for (int k = 1; k <= 5; k++) begin
            @(posedge clk); #1;
            if (k == 2) begin
                check("b2b_first_ready", 64'(bus.ready), 64'(1));
                check("b2b_first_result", 64'(bus.resultado), 64'(30));
                bus.datoA = 32'd100; bus.datoB = 32'd23;
            end else if (k == 5) begin
                check("b2b_second_ready", 64'(bus.ready), 64'(1));
                check("b2b_second_result", 64'(bus.resultado), 64'(123));
            end else begin
                check($sformatf("b2b_ready_low k%0d", k), 64'(bus.ready), 64'(0));
            end
            if (k == 3) bus.start = 1'b0;
        end

        // reset dropped in the middle of a DIV
        @(negedge clk);
        bus.start = 1'b1; bus.operacion = 3'd3; bus.datoA = 32'd1000; bus.datoB = 32'd7;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("midrst_resultado", 64'(bus.resultado), 64'(0));
        check("midrst_busy", 64'(bus.busy), 64'(0));
        check("midrst_error", 64'(bus.error), 64'(0));
        check("midrst_ready", 64'(bus.ready), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        ready_seen = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            if (bus.ready) ready_seen++;
        end
        check("midrst_no_ready", 64'(ready_seen), 64'(0));
        run_op(3'd3, 32'd1000, 32'd7, 1'b0);

        for (int n = 0; n < 40; n++) begin
            op = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 3))
                0: begin a = $urandom; b = $urandom; end
                1: begin a = $urandom_range(0, 15); b = $urandom_range(0, 15); end
                2: begin a = ($urandom & 1) ? 32'hFFFFFFFF : 32'd0; b = ($urandom & 1) ? 32'hFFFFFFFF : $urandom; end
                default: begin a = $urandom; b = a; end
            endcase
            run_op(op, a, b, ($urandom & 3) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
